// File: rtl/tt_um_logic_analyzer_combo_pkg.sv
// Shared definitions for the 8-channel, 16-deep logic analyzer.
// Contents: capture FSM state encoding, trigger mode encoding, memory geometry,
//           and bit positions of the control/status fields on the uio bus.
package tt_um_logic_analyzer_combo_pkg;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 8;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  // uio_in control fields
  localparam int UIO_ARM_BIT   = 0;
  localparam int UIO_READ_BIT  = 1;
  localparam int UIO_MODE_LSB  = 2;
  localparam int UIO_MODE_MSB  = 3;

  // uio_out status fields
  localparam int UIO_ARMED_BIT   = 4;
  localparam int UIO_CAPTURE_BIT = 5;
  localparam int UIO_DONE_BIT    = 6;
  localparam int UIO_LAST_BIT    = 7;

  // Upper nibble is status output, lower nibble is control input.
  localparam logic [7:0] UIO_OE_VAL = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_DONE    = 2'b11
  } la_state_e;

  typedef enum logic [1:0] {
    TRIG_IMMEDIATE  = 2'b00,
    TRIG_ANY_CHANGE = 2'b01,
    TRIG_RISE0      = 2'b10,
    TRIG_FALL0      = 2'b11
  } trig_mode_e;

endpackage

// File: rtl/tt_um_logic_analyzer_combo_la_trigger.sv
// Purpose: edge detection for ARM/READ strobes and trigger evaluation on the probes.
// Latency: outputs are combinational against one cycle of registered history.
// Backpressure: none; every cycle is evaluated.
// Ports: clk/rst_n; ui_in probes; arm_in/read_in raw strobes; mode (latched by top);
//        arm_edge/read_edge rising-edge pulses; trig = trigger condition this cycle.
module la_trigger
  import tt_um_logic_analyzer_combo_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] ui_in,
  input  logic          arm_in,
  input  logic          read_in,
  input  trig_mode_e    mode,
  output logic          arm_edge,
  output logic          read_edge,
  output logic          trig
);

  logic          prev_arm_q,  prev_arm_d;
  logic          prev_read_q, prev_read_d;
  logic [DW-1:0] prev_ui_q,   prev_ui_d;

  always_comb begin
    prev_arm_d  = arm_in;
    prev_read_d = read_in;
    prev_ui_d   = ui_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_arm_q  <= 1'b0;
      prev_read_q <= 1'b0;
      prev_ui_q   <= '0;
    end else begin
      prev_arm_q  <= prev_arm_d;
      prev_read_q <= prev_read_d;
      prev_ui_q   <= prev_ui_d;
    end
  end

  assign arm_edge  = arm_in  & ~prev_arm_q;
  assign read_edge = read_in & ~prev_read_q;

  always_comb begin
    trig = 1'b0;
    case (mode)
      TRIG_IMMEDIATE:  trig = 1'b1;
      TRIG_ANY_CHANGE: trig = (ui_in != prev_ui_q);
      TRIG_RISE0:      trig = ui_in[0] & ~prev_ui_q[0];
      TRIG_FALL0:      trig = ~ui_in[0] & prev_ui_q[0];
      default:         trig = 1'b0;
    endcase
  end

endmodule

// File: rtl/tt_um_logic_analyzer_combo.sv
// Purpose: 8-channel logic analyzer; ARM, wait for trigger, capture 16 samples, step-read.
// Latency: trigger-cycle sample is sample 0; uo_out follows rd_ptr combinationally.
// Backpressure: none; ARM is ignored while armed/capturing, READ only acts when done.
// Ports: ui_in = probes; uio_in[0]=ARM, [1]=READ, [3:2]=trigger mode;
//        uo_out = mem[rd_ptr]; uio_out[7:4] = {rd_ptr==15, DONE, CAPTURE, ARMED}.
module tt_um_logic_analyzer_combo
  import tt_um_logic_analyzer_combo_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  la_state_e     state_q, state_d;
  trig_mode_e    mode_q,  mode_d;
  logic [AW-1:0] wr_q,    wr_d;
  logic [AW-1:0] rd_q,    rd_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic          arm_edge, read_edge, trig;

  // The block is always enabled; uio_in[7:4] carries nothing.
  logic unused_ok;
  assign unused_ok = &{ena, uio_in[7:4], 1'b0};

  la_trigger u_trig (
    .clk       (clk),
    .rst_n     (rst_n),
    .ui_in     (ui_in),
    .arm_in    (uio_in[UIO_ARM_BIT]),
    .read_in   (uio_in[UIO_READ_BIT]),
    .mode      (mode_q),
    .arm_edge  (arm_edge),
    .read_edge (read_edge),
    .trig      (trig)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    mem_we    = 1'b0;
    mem_waddr = wr_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Arm takes priority over a coincident read step.
        if (arm_edge) begin
          state_d = ST_ARMED;
          mode_d  = trig_mode_e'(uio_in[UIO_MODE_MSB:UIO_MODE_LSB]);
          wr_d    = '0;
          rd_d    = '0;
        end else if (read_edge && (state_q == ST_DONE)) begin
          rd_d = rd_q + AW'(1);
        end
      end
      ST_ARMED: begin
        if (trig) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
          wr_d      = AW'(1);
          state_d   = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        mem_we    = 1'b1;
        mem_waddr = wr_q;
        wr_d      = wr_q + AW'(1);
        if (wr_q == LAST_IDX) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (mem_we) begin
      mem_d[mem_waddr] = ui_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= TRIG_IMMEDIATE;
      wr_q    <= '0;
      rd_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign uo_out = mem_q[rd_q];
  assign uio_oe = UIO_OE_VAL;

  always_comb begin
    uio_out                  = '0;
    uio_out[UIO_ARMED_BIT]   = (state_q == ST_ARMED);
    uio_out[UIO_CAPTURE_BIT] = (state_q == ST_CAPTURE);
    uio_out[UIO_DONE_BIT]    = (state_q == ST_DONE);
    uio_out[UIO_LAST_BIT]    = (rd_q == LAST_IDX);
  end

endmodule

// File: tb/tb_tt_um_logic_analyzer_combo.sv
// Directed bench for the logic analyzer: reset, the four trigger modes,
// read stepping with wrap, ARM-vs-READ priority, ignored ARM and mid-capture reset.
module tb_tt_um_logic_analyzer_combo;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks;
  int n_fail;

  tt_um_logic_analyzer_combo dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // Advance one clock; leave the sample point 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm(input logic [1:0] mode);
    uio_in = {4'b0000, mode, 1'b0, 1'b1};
    tick();
    uio_in = 8'h00;
  endtask

  // Two cycles so the next pulse always sees a fresh rising edge.
  task automatic pulse_read();
    uio_in = 8'h02;
    tick();
    uio_in = 8'h00;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ena      = 1'b1;
    ui_in    = 8'h3C;
    uio_in   = 8'h00;
    rst_n    = 1'b1;
    #2;
    rst_n    = 1'b0;
    #1;
    chk("rst_uo_out",  uo_out,  8'h00);
    chk("rst_uio_out", uio_out, 8'h00);
    chk("rst_uio_oe",  uio_oe,  8'hF0);
    tick();
    tick();
    rst_n = 1'b1;
    ui_in = 8'h00;
    tick();
    tick();
    chk("idle_uo_out",  uo_out,  8'h00);
    chk("idle_uio_out", uio_out, 8'h00);
    chk("idle_uio_oe",  uio_oe,  8'hF0);

    // READ in IDLE does nothing.
    pulse_read();
    chk("idle_read_ignored", uio_out, 8'h00);

    // ---- Mode 00: immediate trigger, samples 0..15 ----
    pulse_arm(2'b00);
    chk("m00_armed", uio_out, 8'h10);
    for (int i = 0; i < 16; i++) begin
      ui_in = 8'(i);
      tick();
      if (i == 0)  chk("m00_capture", uio_out, 8'h20);
      if (i == 14) chk("m00_still_capture", uio_out, 8'h20);
    end
    chk("m00_done",      uio_out, 8'h40);
    chk("m00_rd0",       uo_out,  8'h00);
    for (int k = 1; k < 16; k++) begin
      pulse_read();
      chk($sformatf("m00_rd%0d", k), uo_out, 8'(k));
    end
    chk("m00_last_flag", uio_out, 8'hC0);
    pulse_read();
    chk("m00_wrap_data", uo_out,  8'h00);
    chk("m00_wrap_flag", uio_out, 8'h40);

    // ---- Mode 10: rising edge on ui_in[0] ----
    ui_in = 8'h00;
    pulse_arm(2'b10);
    tick();
    tick();
    tick();
    chk("m10_waiting", uio_out, 8'h10);
    ui_in = 8'h01;
    tick();
    chk("m10_capture", uio_out, 8'h20);
    chk("m10_mem0",    uo_out,  8'h01);
    for (int j = 1; j < 16; j++) begin
      ui_in = 8'h40 + 8'(j);
      tick();
      if (j == 14) chk("m10_cap_15", uio_out, 8'h20);
    end
    chk("m10_done", uio_out, 8'h40);
    pulse_read();
    chk("m10_mem1", uo_out, 8'h41);

    // ---- Mode 01: any change; memory retained across re-arm ----
    ui_in = 8'hA5;
    tick();
    tick();
    pulse_arm(2'b01);
    chk("m01_retained", uo_out, 8'h01);
    tick();
    tick();
    tick();
    chk("m01_no_trig", uio_out, 8'h10);
    ui_in = 8'h5A;
    tick();
    chk("m01_mem0",    uo_out,  8'h5A);
    chk("m01_capture", uio_out, 8'h20);
    // ARM during capture must neither restart nor stall the capture.
    ui_in = 8'h66;
    pulse_arm(2'b00);
    chk("arm_ignored", uio_out, 8'h20);
    for (int j = 0; j < 13; j++) tick();
    chk("arm_ign_cap", uio_out, 8'h20);
    tick();
    chk("arm_ign_done", uio_out, 8'h40);
    pulse_read();
    chk("m01_mem1", uo_out, 8'h66);

    // ---- Mode 11: falling edge on ui_in[0] ----
    ui_in = 8'h01;
    tick();
    pulse_arm(2'b11);
    ui_in = 8'h03;
    tick();
    chk("m11_no_trig", uio_out, 8'h10);
    ui_in = 8'h90;
    tick();
    chk("m11_mem0", uo_out, 8'h90);
    for (int j = 1; j < 16; j++) begin
      ui_in = 8'h90 + 8'(j);
      tick();
    end
    chk("m11_done", uio_out, 8'h40);
    pulse_read();
    pulse_read();
    chk("m11_rd2", uo_out, 8'h92);

    // ---- ARM and READ together in DONE: arm wins ----
    uio_in = 8'h03;
    tick();
    uio_in = 8'h00;
    chk("arm_wins_flag", uio_out, 8'h10);
    chk("arm_wins_data", uo_out,  8'h90);

    // ---- Reset mid-capture ----
    ui_in = 8'h77;
    tick();
    tick();
    tick();
    chk("pre_rst_capture", uio_out, 8'h20);
    rst_n = 1'b0;
    #1;
    chk("midrst_uo_out",  uo_out,  8'h00);
    chk("midrst_uio_out", uio_out, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    chk("postrst_uio_out", uio_out, 8'h00);
    chk("postrst_uio_oe",  uio_oe,  8'hF0);
    pulse_read();
    chk("postrst_uo_out",  uo_out,  8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
